exp2_result_drain: RTL
======================

// Module: exp2_result_drain
// PURPOSE
//  Downstream stage for the 10-word doubling shift device. Captures the 100-bit word that device emits
//  every cycle, buffers it in a small FIFO and serialises each word into CHUNK_W-bit beats on a
//  valid/ready output. Decouples the free-running, never-stalling producer from a narrow,
//  back-pressuring consumer. Words arriving while the FIFO is full are dropped and flagged.
// PARAMETERS
//  WORD_W   100  width of one producer word (must be a multiple of CHUNK_W)
//  CHUNK_W  25   output beat width; CHUNKS = WORD_W/CHUNK_W = 4
//  DEPTH    8    FIFO entries (power of two, >= 2)
//  WARMUP   10   cycles after reset during which producer output is pipeline fill and is ignored
// PORTS
//  clk        in   1                  single clock, rising edge
//  rst        in   1                  asynchronous, active-high reset
//  in_word    in   WORD_W             producer word, sampled every cycle
//  in_valid   in   1                  producer word qualifier (tie 1 for free-running producer)
//  out_data   out  CHUNK_W            current beat, most-significant chunk first
//  out_valid  out  1                  beat available
//  out_ready  in   1                  consumer accepts beat when out_valid & out_ready
//  out_last   out  1                  beat is the final (least-significant) chunk of a word
//  level      out  $clog2(DEPTH)+1    words held in FIFO, including the word being serialised
//  overflow   out  1                  sticky: a qualified word was dropped since reset
// BEHAVIOUR
//  - Reset (async, any cycle): out_valid=0, out_last=0, out_data=0, level=0, overflow=0, FIFO
//    emptied, warm-up counter restarts at 0, FSM -> IDLE. Reset mid-word discards partial word.
//  - Warm-up: counter counts 0..WARMUP then saturates; push = in_valid & (cnt==WARMUP) & ~full.
//    First capturable word is the one presented in cycle WARMUP after reset deassertion.
//  - Push latency: word pushed at edge N is visible as out_valid at edge N+1 (earliest).
//  - FSM IDLE: out_valid=0; if FIFO non-empty -> SEND, chunk index=CHUNKS-1 (MSB).
//  - FSM SEND: out_data = head[idx*CHUNK_W +: CHUNK_W]; out_last = (idx==0). On handshake:
//    idx-- ; when handshake on idx==0 pop head, then -> SEND(idx=CHUNKS-1) if further word
//    present after the pop, else IDLE. No bubble between consecutive words.
//  - out_data/out_last stable while out_valid & ~out_ready (AXI-stream style hold).
//  - Full: push while full is dropped, overflow <= 1 (sticky until reset). Exception: if the same
//    cycle pops the head (last-beat handshake) the slot frees and the push is accepted.
//  - Empty + push same cycle: word stored, out_valid rises next cycle (no bypass).
//  - Pointers wrap modulo DEPTH; level = wr - rd in $clog2(DEPTH)+1 bits, never exceeds DEPTH.
// CONFIGURATION
//  EXP2_DRAIN_STATS_EN defined: adds outputs drop_cnt [7:0] (saturating count of dropped words,
//    stops at 8'hFF) and word_cnt [15:0] (words fully emitted, wraps mod 2^16); both reset to 0.
//  Undefined: ports absent, only sticky overflow reports drops; no counter logic.
// STRUCTURE
//  Package exp2_drain_pkg: WORD_W/CHUNK_W/CHUNKS constants, word_t and chunk_t typedefs,
//    drain_state_t enum {IDLE, SEND}.
//  Sub-module exp2_drain_fifo: DEPTH x WORD_W register FIFO (push, pop, head, full, empty, level),
//    async reset. Top holds warm-up counter, serialiser FSM, overflow/stats.
// TESTING
//  1 Warm-up: in_valid=1, words 1..12 one per cycle from reset release, out_ready=1 -> only words
//    presented in cycles >=10 emitted; first output beats 0,0,0,<word> with out_last on beat 4.
//  2 Order: push 100'h0001_..._0004 style word with chunks A,B,C,D -> beats A,B,C,D, out_last on D.
//  3 Back-pressure: out_ready=0 for 20 cycles, push 10 words -> level caps at 8, overflow=1,
//    first 8 words later emitted intact in order, 2 dropped (drop_cnt=2 with STATS_EN).
//  4 Full + pop same cycle: FIFO full, last-beat handshake coincident with push -> push accepted,
//    level stays 8, overflow unchanged.
//  5 Stall hold: deassert out_ready mid-word for 3 cycles -> out_data/out_last unchanged, resumes.
//  6 Reset mid-word: assert rst after beat 2 -> outputs 0 immediately, level=0, warm-up repeats.

Source files
------------

// File: rtl/exp2_drain_pkg.sv
// Shared constants, types and FSM state encoding for the result drain.
package exp2_drain_pkg;
  localparam int WORD_W  = 100;
  localparam int CHUNK_W = 25;
  localparam int CHUNKS  = WORD_W / CHUNK_W;
  localparam int IDX_W   = $clog2(CHUNKS);

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [CHUNK_W-1:0] chunk_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;
endpackage

// File: rtl/exp2_drain_fifo.sv
// DEPTH x WORD_W register FIFO; the caller only pushes when a slot is free
// (or is being freed by a pop in the same cycle).
module exp2_drain_fifo
  import exp2_drain_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  word_t         pushWord,
  input  logic          pop,
  output word_t         head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  word_t       mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= pushWord;
  end

  assign level = wrPtr - rdPtr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rdPtr[AW-1:0]];
endmodule

// File: rtl/exp2_result_drain.sv
// Buffers free-running producer words and serialises them MSB-chunk first.
// Optional stats outputs (drop_cnt, word_cnt) are built when EXP2_DRAIN_STATS_EN is defined.
// Output handshake: a beat transfers on a rising edge where out_valid & out_ready; while
// out_valid is high and out_ready low, out_data/out_last hold and out_valid stays high.
module exp2_result_drain
  import exp2_drain_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WARMUP = 10,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(WARMUP + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  word_t           in_word,
  input  logic            in_valid,
  output chunk_t          out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [LW-1:0]   level,
  output logic            overflow,
`ifdef EXP2_DRAIN_STATS_EN
  output logic [7:0]      drop_cnt,
  output logic [15:0]     word_cnt,
`endif
  output drain_state_t    stateDbg
);
  logic [CW-1:0] warmCnt;
  logic          warm;
  logic          qualified;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  word_t         head;
  drain_state_t  state, stateNext;
  idx_t          idx, idxNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) warmCnt <= '0;
    else if (warmCnt != CW'(WARMUP)) warmCnt <= warmCnt + 1'b1;
  end

  assign warm      = (warmCnt == CW'(WARMUP));
  assign qualified = in_valid & warm;
  // A last-beat pop frees the head slot in time for a same-cycle push.
  assign push      = qualified & (~full | pop);
  assign drop      = qualified & full & ~pop;

  exp2_drain_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushWord (in_word),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          stateNext = SEND;
          idxNext   = idx_t'(CHUNKS - 1);
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = head[int'(idx)*CHUNK_W +: CHUNK_W];
        out_last  = (idx == '0);
        if (out_ready) begin
          if (idx == '0) begin
            pop = 1'b1;
            // Stay in SEND when another word remains, including one pushed this cycle.
            stateNext = ((level > LW'(1)) || qualified) ? SEND : IDLE;
            idxNext   = idx_t'(CHUNKS - 1);
          end else begin
            idxNext = idx - 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef EXP2_DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      word_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end
`endif

  assign stateDbg = state;
endmodule
